// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state encodings, iteration
// count, data/double-data widths and the helpers for operand magnitude and
// final sign correction.
package div_unit_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DOUBLE_DATA_W = 64;
  localparam int unsigned DIV_CYCLE     = 32;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_BUSY = 2'd1,
    DIV_STATE_DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand: negate only when it is a negative signed value.
  function automatic logic [DATA_W-1:0] div_magnitude(
    input logic              is_signed,
    input logic [DATA_W-1:0] value
  );
    return (is_signed && value[DATA_W-1]) ? -value : value;
  endfunction

  // Apply sign correction and pack as {remainder, quotient} for HI/LO.
  function automatic logic [DOUBLE_DATA_W-1:0] div_pack(
    input logic [DATA_W-1:0] quo_mag,
    input logic [DATA_W-1:0] rem_mag,
    input logic              neg_quo,
    input logic              neg_rem
  );
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    quo = neg_quo ? -quo_mag : quo_mag;
    rem = neg_rem ? -rem_mag : rem_mag;
    return {rem, quo};
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational radix-2 restoring division step.
// Shifts {rem, quo} left by one, trial-subtracts the divisor magnitude in
// 33 bits, and either keeps the difference (quotient bit 1) or restores
// (quotient bit 0).
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] rem_shift;
  logic [DATA_W:0] diff;

  assign rem_shift = {rem, quo[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, divisor};

  // Keep the difference when the trial subtraction did not go negative.
  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    if (!diff[DATA_W]) begin
      rem_next = diff[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit divider for MIPS DIV/DIVU, one quotient bit per
// cycle, producing {HI, LO} = {remainder, quotient}.
// Optional build macro DIV_ZERO_FAST_EN: a divisor of zero skips the
// iteration and finishes in one cycle with identical result values.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned kDivCycle = DIV_CYCLE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     start,
  input  logic                     signed_div,
  input  logic [DATA_W-1:0]        operand_1,
  input  logic [DATA_W-1:0]        operand_2,
  output logic                     busy,
  output logic                     done,
  output logic [DOUBLE_DATA_W-1:0] result
);

  localparam int unsigned          CNT_W    = $clog2(kDivCycle);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(kDivCycle - 1);

  div_state_e        state;
  div_state_e        state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_mag_q;
  logic              signed_q;
  logic              dvd_sign_q;
  logic              dvs_sign_q;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;
  logic              dvd_neg;
  logic              dvs_neg;
  logic              idle_or_done;
  logic              accept;
  logic              go_fast;
  logic              last_step;

  // Request decode: start is only honoured between operations, flush wins.
  assign idle_or_done = (state == DIV_STATE_IDLE) || (state == DIV_STATE_DONE);
  assign accept       = idle_or_done && start && !flush;
  assign last_step    = (state == DIV_STATE_BUSY) && (count == '0);

  assign dvd_mag = div_magnitude(signed_div, operand_1);
  assign dvs_mag = div_magnitude(signed_div, operand_2);
  assign dvd_neg = signed_div & operand_1[DATA_W-1];
  assign dvs_neg = signed_div & operand_2[DATA_W-1];

`ifdef DIV_ZERO_FAST_EN
  assign go_fast = (operand_2 == '0);
`else
  assign go_fast = 1'b0;
`endif

  assign busy = (state == DIV_STATE_BUSY);
  assign done = (state == DIV_STATE_DONE);

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_mag_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking is reserved for combinational code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      DIV_STATE_IDLE: begin
        if (start) state_next = go_fast ? DIV_STATE_DONE : DIV_STATE_BUSY;
      end
      DIV_STATE_BUSY: begin
        if (count == '0) state_next = DIV_STATE_DONE;
      end
      DIV_STATE_DONE: begin
        if (start) state_next = go_fast ? DIV_STATE_DONE : DIV_STATE_BUSY;
        else       state_next = DIV_STATE_IDLE;
      end
      default: state_next = DIV_STATE_IDLE;
    endcase
    if (flush) state_next = DIV_STATE_IDLE;
  end

  // Operand latch, iteration counter and partial remainder/quotient.
  // NOTE: the datapath registers are reset as well, so nothing stale from an
  // aborted operation survives a reset and simulation never sees X here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_mag_q  <= '0;
      signed_q   <= 1'b0;
      dvd_sign_q <= 1'b0;
      dvs_sign_q <= 1'b0;
    end else if (accept) begin
      count      <= CNT_LAST;
      rem_q      <= '0;
      quo_q      <= dvd_mag;
      dvs_mag_q  <= dvs_mag;
      signed_q   <= signed_div;
      dvd_sign_q <= operand_1[DATA_W-1];
      dvs_sign_q <= operand_2[DATA_W-1];
    end else if (busy && !flush) begin
      count <= count - 1'b1;
      rem_q <= step_rem;
      quo_q <= step_quo;
    end
  end

  // Result register: loaded only on entry to DONE, otherwise held
  // (flush and IDLE leave it alone).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else if (accept && go_fast) begin
      // Divide by zero: the natural algorithm yields all-ones and |dividend|.
      result <= div_pack('1, dvd_mag, dvd_neg ^ dvs_neg, dvd_neg);
    end else if (last_step && !flush) begin
      result <= div_pack(step_quo, step_rem,
                         signed_q & (dvd_sign_q ^ dvs_sign_q),
                         signed_q & dvd_sign_q);
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the EX stage, producing the `{HI, LO}` = `{remainder, quotient}` pair for MIPS `DIV`/`DIVU`. It supplies the division path that the multiply/divide unit leaves unimplemented and sits beside it, feeding the HI/LO write path. It uses a radix-2 restoring algorithm on operand magnitudes with final sign correction, one quotient bit per cycle. The EX stage holds the pipeline while `busy` is high.

## Interface
- `kDivCycle`, 32: iteration count, equal to the operand width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `flush` in 1: synchronous abort of the current operation.
- `start` in 1: request a division; sampled only in IDLE/DONE.
- `signed_div` in 1: 1 = `DIV` (two's complement), 0 = `DIVU`.
- `operand_1` in 32: dividend.
- `operand_2` in 32: divisor.
- `busy` out 1: high while iterating; the stage stalls on it.
- `done` out 1: single-cycle pulse; `result` is valid from this cycle on.
- `result` out 64: `[63:32]` remainder (HI), `[31:0]` quotient (LO).

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: iterating; counter counts 31 down to 0.
  - DONE: one cycle, `done`=1.
- Transitions:
  - IDLE/DONE with `start` → BUSY: latch magnitudes, sign flags and `signed_div`.
  - DONE without `start` → IDLE.
  - BUSY with counter==0 → DONE: `result` is loaded with sign-corrected values.
  - Any state with `flush` → IDLE.
- Magnitudes: when `signed_div` is 1 and the operand's bit 31 is set, use the negated operand; otherwise use it raw.
- Each BUSY step:
  - Shift `{rem, quo}` left by 1.
  - Trial-subtract the divisor magnitude from `rem` in 33 bits.
  - If non-negative: keep the difference and set the quotient LSB to 1.
  - Otherwise: restore and set it to 0.
- Sign fix, applied only when `signed_div` is 1:
  - Quotient is negated iff the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
- Overflow: `0x80000000 / 0xFFFFFFFF` signed gives q=`0x80000000`, r=0. No trap.
- Divide by zero: defined results, computed by the natural algorithm.
  - Magnitude q=`0xFFFFFFFF`, r=|dividend|, then the sign fix above.
  - Divisor 0 counts as positive.
- `result` holds its value until the next DONE or reset. It is unchanged by flush and by IDLE.
- `start` while BUSY is ignored.
- `start` and `flush` in the same cycle: flush wins and the request is dropped.

## Timing
- Reset (async, `rst`=0):
  - State goes to IDLE and the counter to 0.
  - `busy`=0, `done`=0, `result`=0 immediately, without waiting for a clock edge.
  - Applies mid-operation.
- Start accepted at edge E0:
  - `busy`=1 in cycles 1..32 after E0.
  - `done`=1 in cycle 33.
  - A stalled stage reads `result` in cycle 33.
- Back-to-back: `start` during the DONE cycle is accepted, so the next `done` comes 33 cycles later.
- Flush at edge Ef: `busy`=0 from the cycle after Ef, and no `done` follows.
- `busy` and `done` are never high together.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: an accepted request with divisor 0 goes directly to DONE. `done` is high in cycle 1 after E0, `busy` never rises, and `result` is identical to the non-fast values.
  - Undefined: divisor 0 takes the full 33-cycle path.
- Only latency differs between the two builds, never the values.

## Structure
- The `define/` header set holds:
  - State encodings (`DIV_STATE_IDLE/BUSY/DONE`).
  - `DIV_CYCLE`.
  - The 64-bit double-data bus width.
- The EX stage decodes funct into `start`/`signed_div`, using the existing funct codes.
- One sub-module, `div_step`: combinational single restoring step. It takes `rem`, `quo` and the divisor magnitude, and returns the next `rem`, `quo`.
- Counter, state register, operand latch and sign fix stay in `div_unit`.

## Test plan
- Unsigned 100 / 7:
  - `result` = {`0x00000002`, `0x0000000E`}.
  - `done` exactly 33 cycles after start; `busy` high for 32 cycles.
- Signed -7 / 2:
  - q=`0xFFFFFFFD`, r=`0xFFFFFFFF`.
  - Repeat with 7 / -2: q=`0xFFFFFFFD`, r=1.
- Signed `0x80000000` / `0xFFFFFFFF`: q=`0x80000000`, r=0, no other effect.
- Divide by zero:
  - Unsigned 5/0: q=`0xFFFFFFFF`, r=5.
  - Signed -5/0: q=1, r=`0xFFFFFFFB`.
  - `done` at cycle 33, or cycle 1 with `DIV_ZERO_FAST_EN`.
- Flush and restart:
  - Flush at cycle 10 of a 100/7: no `done`, `busy` low next cycle, `result` keeps the prior value.
  - Start in the same cycle as flush is dropped.
  - A fresh 9/3 then gives q=3, r=0.
- Reset and back-to-back:
  - `rst` low mid-BUSY: all outputs 0 asynchronously.
  - After release, start during DONE chains two divisions, with `done` pulses 33 cycles apart.
